// File: rtl/rggen_register_access_controller.sv
// Register access controller: one host request at a time is forwarded to register slices and one response is returned.
// Latency: o_reg_valid is high in the cycle after acceptance, and the response comes at least two cycles after acceptance.
// Backpressure: o_host_ready is high only in IDLE, and the response is held until i_host_rsp_ready is seen.
// Optional feature: define RGGEN_ACCESS_TIMEOUT_EN to end ACCESS with a slave error after TIMEOUT_CYCLES wait cycles.
module rggen_register_access_controller #(
    parameter int ADDRESS_WIDTH  = 8,
    parameter int BUS_WIDTH      = 32,
    parameter int REGISTERS      = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_host_valid,
    output logic                           o_host_ready,
    input  logic [1:0]                     i_host_access,
    input  logic [ADDRESS_WIDTH-1:0]       i_host_address,
    input  logic [BUS_WIDTH-1:0]           i_host_write_data,
    input  logic [BUS_WIDTH-1:0]           i_host_strobe,
    output logic                           o_host_rsp_valid,
    input  logic                           i_host_rsp_ready,
    output logic [1:0]                     o_host_status,
    output logic [BUS_WIDTH-1:0]           o_host_read_data,
    output logic                           o_reg_valid,
    output logic [1:0]                     o_reg_access,
    output logic [ADDRESS_WIDTH-1:0]       o_reg_address,
    output logic [BUS_WIDTH-1:0]           o_reg_write_data,
    output logic [BUS_WIDTH-1:0]           o_reg_strobe,
    input  logic [REGISTERS-1:0]           i_reg_active,
    input  logic [REGISTERS-1:0]           i_reg_ready,
    input  logic [2*REGISTERS-1:0]         i_reg_status,
    input  logic [BUS_WIDTH*REGISTERS-1:0] i_reg_read_data
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        RESPONSE = 2'd2
    } state_t;

    localparam logic [1:0] STATUS_OKAY  = 2'b00;
    localparam logic [1:0] STATUS_SLVERR = 2'b10;
    localparam logic [1:0] STATUS_DECERR = 2'b11;

    // Parameter sanity; a bad configuration stops elaboration.
    generate
        if (REGISTERS < 1 || TIMEOUT_CYCLES < 1 || (BUS_WIDTH % 8) != 0) begin : g_bad_params
            $error("rggen_register_access_controller: illegal parameter set");
        end
    endgenerate

    state_t                 state;
    state_t                 state_nxt;
    logic                   capture;
    logic [1:0]             cap_status;
    logic [BUS_WIDTH-1:0]   cap_data;
    logic                   sel_ready;
    logic [1:0]             sel_status;
    logic [BUS_WIDTH-1:0]   sel_data;
    logic                   no_active;
    logic                   multi_active;
    logic                   timeout_hit;

    assign o_host_ready     = (state == IDLE);
    assign o_reg_valid      = (state == ACCESS);
    assign o_host_rsp_valid = (state == RESPONSE);

    assign no_active    = (i_reg_active == '0);
    // Clearing the lowest set bit leaves something only when two or more slices claim the address.
    assign multi_active = ((i_reg_active & (i_reg_active - REGISTERS'(1))) != '0);

    // OR-mux the slice outputs by the active vector; only meaningful when exactly one bit is set.
    always_comb begin
        sel_ready  = 1'b0;
        sel_status = '0;
        sel_data   = '0;
        for (int k = 0; k < REGISTERS; k++) begin
            if (i_reg_active[k]) begin
                sel_ready  = sel_ready | i_reg_ready[k];
                sel_status = sel_status | i_reg_status[2*k +: 2];
                sel_data   = sel_data | i_reg_read_data[BUS_WIDTH*k +: BUS_WIDTH];
            end
        end
    end

`ifdef RGGEN_ACCESS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] timeout_cnt;

    // Count ACCESS cycles; cleared whenever the FSM is elsewhere, so it restarts from 0 on every entry.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            timeout_cnt <= '0;
        end else if (state != ACCESS) begin
            timeout_cnt <= '0;
        end else begin
            timeout_cnt <= timeout_cnt + CW'(1);
        end
    end

    // The current cycle is the last allowed ACCESS cycle.
    assign timeout_hit = (timeout_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    // No counter: ACCESS waits for the slice for as long as it takes.
    assign timeout_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and response selection.
    always_comb begin
        state_nxt  = state;
        capture    = 1'b0;
        cap_status = STATUS_OKAY;
        cap_data   = '0;
        case (state)
            IDLE: begin
                if (i_host_valid) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (no_active) begin
                    capture    = 1'b1;
                    cap_status = STATUS_DECERR;
                end else if (multi_active) begin
                    capture    = 1'b1;
                    cap_status = STATUS_SLVERR;
                end else if (sel_ready) begin
                    capture    = 1'b1;
                    cap_status = sel_status;
                    // Writes never return data.
                    cap_data   = o_reg_access[0] ? '0 : sel_data;
                end else if (timeout_hit) begin
                    capture    = 1'b1;
                    cap_status = STATUS_SLVERR;
                end
                if (capture) begin
                    state_nxt = RESPONSE;
                end
            end
            RESPONSE: begin
                if (i_host_rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Latch the request into the register-side outputs on acceptance; they stay put through ACCESS.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_reg_access     <= '0;
            o_reg_address    <= '0;
            o_reg_write_data <= '0;
            o_reg_strobe     <= '0;
        end else if ((state == IDLE) && i_host_valid) begin
            o_reg_access     <= i_host_access;
            o_reg_address    <= i_host_address;
            o_reg_write_data <= i_host_write_data;
            o_reg_strobe     <= i_host_strobe;
        end
    end

    // Capture the response when ACCESS ends; held through RESPONSE.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_host_status    <= STATUS_OKAY;
            o_host_read_data <= '0;
        end else if (capture) begin
            o_host_status    <= cap_status;
            o_host_read_data <= cap_data;
        end
    end

endmodule

// File: tb/tb_rggen_register_access_controller.sv
// Bench for rggen_register_access_controller: table of request vectors plus hand-written reset/timeout sequences.
// Expected responses go into a scoreboard queue at acceptance and are compared when o_host_rsp_valid appears.
// Outputs are sampled on the falling edge; inputs are driven on the falling edge or just after the rising edge.
module tb_rggen_register_access_controller;

    localparam int AW = 8;
    localparam int BW = 32;
    localparam int NR = 4;
    localparam int TO = 4;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b1;
    logic              i_host_valid = 1'b0;
    logic              o_host_ready;
    logic [1:0]        i_host_access = '0;
    logic [AW-1:0]     i_host_address = '0;
    logic [BW-1:0]     i_host_write_data = '0;
    logic [BW-1:0]     i_host_strobe = '0;
    logic              o_host_rsp_valid;
    logic              i_host_rsp_ready = 1'b0;
    logic [1:0]        o_host_status;
    logic [BW-1:0]     o_host_read_data;
    logic              o_reg_valid;
    logic [1:0]        o_reg_access;
    logic [AW-1:0]     o_reg_address;
    logic [BW-1:0]     o_reg_write_data;
    logic [BW-1:0]     o_reg_strobe;
    logic [NR-1:0]     i_reg_active = '0;
    logic [NR-1:0]     i_reg_ready = '0;
    logic [2*NR-1:0]   i_reg_status = '0;
    logic [BW*NR-1:0]  i_reg_read_data = '0;

    rggen_register_access_controller #(
        .ADDRESS_WIDTH (AW),
        .BUS_WIDTH     (BW),
        .REGISTERS     (NR),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_host_valid     (i_host_valid),
        .o_host_ready     (o_host_ready),
        .i_host_access    (i_host_access),
        .i_host_address   (i_host_address),
        .i_host_write_data(i_host_write_data),
        .i_host_strobe    (i_host_strobe),
        .o_host_rsp_valid (o_host_rsp_valid),
        .i_host_rsp_ready (i_host_rsp_ready),
        .o_host_status    (o_host_status),
        .o_host_read_data (o_host_read_data),
        .o_reg_valid      (o_reg_valid),
        .o_reg_access     (o_reg_access),
        .o_reg_address    (o_reg_address),
        .o_reg_write_data (o_reg_write_data),
        .o_reg_strobe     (o_reg_strobe),
        .i_reg_active     (i_reg_active),
        .i_reg_ready      (i_reg_ready),
        .i_reg_status     (i_reg_status),
        .i_reg_read_data  (i_reg_read_data)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [1:0]    acc;
        logic [AW-1:0] addr;
        logic [BW-1:0] wdata;
        logic [BW-1:0] strb;
        logic [NR-1:0] active;
        int            delay;     // not-ready ACCESS cycles before the slice asserts ready
        logic [1:0]    rstatus;
        logic [BW-1:0] rdata;
        int            hold;      // cycles i_host_rsp_ready stays low once the response is up
        logic [1:0]    exp_status;
        logic [BW-1:0] exp_data;
        int            exp_lat;   // falling edges from acceptance edge to first o_host_rsp_valid
    } vec_t;

    typedef struct packed {
        logic [1:0]    st;
        logic [BW-1:0] d;
    } rsp_t;

    rsp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] acc, input logic [AW-1:0] addr,
                                input logic [BW-1:0] wdata, input logic [BW-1:0] strb,
                                input logic [NR-1:0] active, input int delay,
                                input logic [1:0] rstatus, input logic [BW-1:0] rdata, input int hold);
        vec_t v;
        int   n;
        v.acc = acc; v.addr = addr; v.wdata = wdata; v.strb = strb;
        v.active = active; v.delay = delay; v.rstatus = rstatus; v.rdata = rdata; v.hold = hold;
        n = $countones(active);
        if (n == 0) begin
            v.exp_status = 2'b11; v.exp_data = '0; v.exp_lat = 2;
        end else if (n > 1) begin
            v.exp_status = 2'b10; v.exp_data = '0; v.exp_lat = 2;
        end else if (delay >= TO + 100) begin
            // slice never ready: only the timeout can end ACCESS
            v.exp_status = 2'b10; v.exp_data = '0; v.exp_lat = TO + 1;
        end else begin
            v.exp_status = rstatus; v.exp_data = acc[0] ? '0 : rdata; v.exp_lat = delay + 2;
        end
        return v;
    endfunction

    task automatic drive_slices(input vec_t v);
        for (int k = 0; k < NR; k++) begin
            i_reg_status[2*k +: 2]     = v.active[k] ? v.rstatus : 2'b01;
            i_reg_read_data[BW*k +: BW] = v.active[k] ? v.rdata : (32'hDEAD0000 | 32'(k));
        end
        i_reg_active = v.active;
        i_reg_ready  = '0;
    endtask

    task automatic drive_req(input vec_t v);
        i_host_valid      = 1'b1;
        i_host_access     = v.acc;
        i_host_address    = v.addr;
        i_host_write_data = v.wdata;
        i_host_strobe     = v.strb;
        drive_slices(v);
        @(posedge i_clk);
        #1;
        // scramble host inputs so a register side that follows them live is caught
        i_host_valid      = 1'b0;
        i_host_access     = ~v.acc;
        i_host_address    = ~v.addr;
        i_host_write_data = ~v.wdata;
        i_host_strobe     = ~v.strb;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_rst_host"}, {60'd0, o_host_ready, o_host_rsp_valid, o_host_status}, {60'd0, 1'b1, 1'b0, 2'b00});
        chk({tag, "_rst_rdata"}, {32'd0, o_host_read_data}, 64'd0);
        chk({tag, "_rst_reg"}, {52'd0, o_reg_valid, o_reg_access, o_reg_address, (|o_reg_write_data), (|o_reg_strobe)}, 64'd0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int   lat;
        int   regc;
        bit   got;
        bit   stable_ok;
        bit   hold_ok;
        rsp_t e;
        @(negedge i_clk);
        chk({tag, "_idle_ready"}, {63'd0, o_host_ready}, 64'd1);
        drive_req(v);
        e.st = v.exp_status;
        e.d  = v.exp_data;
        sb.push_back(e);
        lat = 0; regc = 0; got = 1'b0; stable_ok = 1'b1;
        while (!got && lat < 60) begin
            @(negedge i_clk);
            lat++;
            if (o_host_rsp_valid) begin
                got = 1'b1;
            end else if (o_reg_valid) begin
                regc++;
                if (o_reg_access !== v.acc || o_reg_address !== v.addr ||
                    o_reg_write_data !== v.wdata || o_reg_strobe !== v.strb)
                    stable_ok = 1'b0;
                i_reg_ready = (regc > v.delay) ? v.active : '0;
            end else begin
                stable_ok = 1'b0;
            end
        end
        if (!got) begin
            errors++;
            checks++;
            $display("FAIL %s_rsp_wait: no response after %0d cycles, required within %0d", tag, lat, v.exp_lat);
            void'(sb.pop_front());
            i_rst = 1'b1; #2; i_rst = 1'b0;
            return;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(v.exp_lat));
        chk({tag, "_reg_cycles"}, 64'(regc), 64'(v.exp_lat - 1));
        chk({tag, "_reg_stable"}, {63'd0, stable_ok}, 64'd1);
        if (sb.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL %s_scoreboard: response with empty queue, required an entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_status"}, {62'd0, o_host_status}, {62'd0, e.st});
            chk({tag, "_rdata"}, {32'd0, o_host_read_data}, {32'd0, e.d});
        end
        chk({tag, "_rsp_flags"}, {62'd0, o_reg_valid, o_host_ready}, 64'd0);
        hold_ok = 1'b1;
        for (int h = 0; h < v.hold; h++) begin
            @(negedge i_clk);
            if (!o_host_rsp_valid || o_host_status !== v.exp_status || o_host_read_data !== v.exp_data)
                hold_ok = 1'b0;
        end
        if (v.hold > 0) chk({tag, "_rsp_hold"}, {63'd0, hold_ok}, 64'd1);
        // offer a new request in the same cycle the response is taken; it must not be accepted
        i_host_rsp_ready = 1'b1;
        i_host_valid     = 1'b1;
        @(posedge i_clk);
        #1;
        i_host_rsp_ready = 1'b0;
        i_host_valid     = 1'b0;
        i_reg_ready      = '0;
        i_reg_active     = '0;
        @(negedge i_clk);
        chk({tag, "_back_idle"}, {61'd0, o_host_ready, o_host_rsp_valid, o_reg_valid}, {61'd0, 3'b100});
    endtask

    // Hold a never-ready access for some cycles, then pulse reset away from any clock edge.
    task automatic access_then_reset(input int wait_cycles, input string tag);
        vec_t v;
        bit   ok;
        v = mk(2'b00, 8'h04, 32'h0, 32'hFFFFFFFF, 4'b0010, 1000, 2'b00, 32'h11111111, 0);
        @(negedge i_clk);
        drive_req(v);
        ok = 1'b1;
        for (int c = 0; c < wait_cycles; c++) begin
            @(negedge i_clk);
            if (!o_reg_valid || o_host_rsp_valid || o_reg_address !== v.addr) ok = 1'b0;
        end
        chk({tag, "_in_access"}, {63'd0, ok}, 64'd1);
        #2;
        i_rst = 1'b1;
        #1;
        check_reset(tag);
        @(negedge i_clk);
        i_rst        = 1'b0;
        i_reg_active = '0;
        @(negedge i_clk);
        chk({tag, "_after_rst"}, {62'd0, o_host_ready, o_reg_valid}, {62'd0, 2'b10});
    endtask

    initial begin
        vecs[0] = mk(2'b01, 8'h04, 32'h12345678, 32'hFFFFFFFF, 4'b0010, 0, 2'b00, 32'hAAAA5555, 0);
        vecs[1] = mk(2'b00, 8'h08, 32'h00000000, 32'hFFFFFFFF, 4'b0100, 3, 2'b00, 32'hCAFEF00D, 0);
        vecs[2] = mk(2'b00, 8'hFC, 32'h00000000, 32'hFFFFFFFF, 4'b0000, 0, 2'b00, 32'h0BADBEEF, 0);
        vecs[3] = mk(2'b00, 8'h00, 32'h00000000, 32'h0000FFFF, 4'b1001, 0, 2'b00, 32'h77777777, 0);
        vecs[4] = mk(2'b00, 8'h0C, 32'h00000000, 32'hFF00FF00, 4'b1000, 1, 2'b10, 32'h00000055, 0);
        vecs[5] = mk(2'b11, 8'h00, 32'hA5A5A5A5, 32'h00FF00FF, 4'b0001, 2, 2'b00, 32'h99999999, 0);
        vecs[6] = mk(2'b00, 8'h00, 32'h00000000, 32'hFFFFFFFF, 4'b0001, 0, 2'b00, 32'h01234567, 5);
        vecs[7] = mk(2'b10, 8'h0C, 32'h00000000, 32'hFFFFFFFF, 4'b1000, 4, 2'b00, 32'hFEEDFACE, 2);

        #3;
        check_reset("por");
        @(negedge i_clk);
        i_rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end
        chk("sb_empty", 64'(sb.size()), 64'd0);

        access_then_reset(2, "mid_access");

`ifdef RGGEN_ACCESS_TIMEOUT_EN
        run_vec(mk(2'b00, 8'h04, 32'h0, 32'hFFFFFFFF, 4'b0010, 1000, 2'b00, 32'h33333333, 0), "timeout");
`else
        access_then_reset(30, "no_timeout");
`endif

        // reset while a response is pending
        @(negedge i_clk);
        drive_req(vecs[2]);
        @(negedge i_clk);
        @(negedge i_clk);
        chk("rsp_pend_valid", {62'd0, o_host_rsp_valid, o_host_status[0]}, {62'd0, 2'b11});
        #2;
        i_rst = 1'b1;
        #1;
        check_reset("rsp_rst");
        @(negedge i_clk);
        i_rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rggen_register_access_controller.md
RGGEN_REGISTER_ACCESS_CONTROLLER -- requirements
Module: rggen_register_access_controller

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 8, meaning width of the byte address.
REQ-002 SHALL have parameter BUS_WIDTH, default 32, meaning host and register data width in bits (multiple of 8).
REQ-003 SHALL have parameter REGISTERS, default 4, meaning number of register slices served (>=1).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning wait-cycle limit in ACCESS (>=1).
REQ-005 SHALL have ports i_clk  in  1  clock; i_rst  in  1  reset; one clock, reset asynchronous and active-high.
REQ-006 SHALL have ports i_host_valid  in  1  request valid; o_host_ready  out  1  request accepted.
REQ-007 SHALL have ports i_host_access  in  2  bit0 = write, bit1 = non-posted; i_host_address  in  ADDRESS_WIDTH  byte address.
REQ-008 SHALL have ports i_host_write_data  in  BUS_WIDTH  write data; i_host_strobe  in  BUS_WIDTH  bit-enable mask.
REQ-009 SHALL have ports o_host_rsp_valid  out  1  response valid; i_host_rsp_ready  in  1  response taken.
REQ-010 SHALL have ports o_host_status  out  2  00 OKAY, 10 slave error, 11 decode error; o_host_read_data  out  BUS_WIDTH.
REQ-011 SHALL have ports o_reg_valid  out  1; o_reg_access  out  2; o_reg_address  out  ADDRESS_WIDTH; o_reg_write_data, o_reg_strobe  out  BUS_WIDTH.
REQ-012 SHALL have ports i_reg_active, i_reg_ready  in  REGISTERS; i_reg_status  in  2*REGISTERS; i_reg_read_data  in  BUS_WIDTH*REGISTERS; slice k at [k*W +: W].

Function
REQ-013 SHALL implement FSM IDLE, ACCESS, RESPONSE; o_host_ready = 1 only in IDLE.
REQ-014 IDLE: on i_host_valid SHALL register access/address/write_data/strobe into o_reg_* and go ACCESS next cycle.
REQ-015 ACCESS: o_reg_valid SHALL be 1; o_reg_* SHALL hold stable until ACCESS exits.
REQ-016 ACCESS, i_reg_active all 0: SHALL capture status 11, read data 0, go RESPONSE.
REQ-017 ACCESS, more than one i_reg_active bit set: SHALL capture status 10, read data 0, go RESPONSE.
REQ-018 ACCESS, exactly one active bit k with i_reg_ready[k] = 1: SHALL capture slice k status and read data (read data forced 0 on writes), go RESPONSE.
REQ-019 ACCESS, one active bit k with i_reg_ready[k] = 0: SHALL stay in ACCESS.
REQ-020 RESPONSE: o_host_rsp_valid = 1 with status/read data held; on i_host_rsp_ready go IDLE; new request not accepted in same cycle.
REQ-021 Latency: request accepted edge N, o_reg_valid high cycle N+1, earliest o_host_rsp_valid cycle N+2.
REQ-022 Outside ACCESS, o_reg_valid SHALL be 0; outside RESPONSE, o_host_rsp_valid SHALL be 0.

Reset
REQ-023 On i_rst = 1, SHALL go to IDLE asynchronously, at any state, including mid-ACCESS and RESPONSE.
REQ-024 Reset values: o_host_ready 1, o_host_rsp_valid 0, o_host_status 00, o_host_read_data 0, o_reg_valid 0, all o_reg_* 0, timeout counter 0.

Configuration
REQ-025 Macro RGGEN_ACCESS_TIMEOUT_EN defined: SHALL count ACCESS cycles from 0, cleared on ACCESS entry.
REQ-026 With macro, TIMEOUT_CYCLES ACCESS cycles without REQ-016/017/018 exit: SHALL capture status 10, read data 0, go RESPONSE.
REQ-027 Without macro: no counter; ACCESS SHALL wait indefinitely for ready.

Verification
REQ-028 Write 0x12345678 to address 0x04 (slice 1 active, ready immediately) -> o_reg_valid for 1 cycle, status 00, read_data 0.
REQ-029 Read 0x08, slice 2 returns 0xCAFEF00D after 3 not-ready cycles -> response 0xCAFEF00D, status 00, o_reg_* stable throughout.
REQ-030 Read unmapped 0xFC (no active) -> status 11, read_data 0, response at cycle N+2.
REQ-031 Slices 0 and 3 both active -> status 10.
REQ-032 i_host_rsp_ready low 5 cycles -> response held; i_rst pulsed mid-ACCESS -> immediate IDLE with REQ-024 values.
REQ-033 With RGGEN_ACCESS_TIMEOUT_EN and TIMEOUT_CYCLES = 4, active slice never ready -> status 10 after 4 ACCESS cycles.
